// File: rtl/ibex_shadow_stack_ctrl.sv
// Return-address shadow stack: calls push the link address, returns pop and compare it with the
// actual target. Errors are reported one cycle later with a cause code and a sticky flag.
module ibex_shadow_stack_ctrl #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 16,
  parameter bit          WrapOnFull = 1'b0,
  parameter bit          IgnoreLsb  = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         push_i,
  input  logic [DataWidth-1:0]         push_addr_i,
  input  logic                         pop_i,
  input  logic [DataWidth-1:0]         pop_addr_i,
  input  logic                         flush_i,
  input  logic                         err_clr_i,
  output logic                         err_o,
  output logic [1:0]                   err_cause_o,
  output logic                         err_sticky_o,
  output logic [$clog2(Depth+1)-1:0]   depth_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);
  localparam logic [DataWidth-1:0] CmpMask =
    IgnoreLsb ? {{(DataWidth-1){1'b1}}, 1'b0} : {DataWidth{1'b1}};

  typedef enum logic [1:0] {
    CauseNone      = 2'b00,
    CauseMismatch  = 2'b01,
    CauseOverflow  = 2'b10,
    CauseUnderflow = 2'b11
  } cause_e;

  // Pointer arithmetic wraps at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
    return (p == '0) ? PtrW'(Depth-1) : p - 1'b1;
  endfunction

  function automatic logic addr_match(input logic [DataWidth-1:0] a,
                                      input logic [DataWidth-1:0] b);
    return ((a ^ b) & CmpMask) == '0;
  endfunction

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      top_q, top_d, wr_ptr;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 wr_en, is_full, is_empty, top_ok;
  cause_e               cause_d;
  logic                 err_p1, sticky_p1;
  cause_e               cause_p1;

  assign is_full  = (cnt_q == CntW'(Depth));
  assign is_empty = (cnt_q == '0);
  assign top_ok   = addr_match(mem[top_q], pop_addr_i);

  // Stage p0: decide the stack update and any error cause for this cycle
  always_comb begin
    top_d   = top_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_ptr  = ptr_inc(top_q);
    cause_d = CauseNone;
    if (flush_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      case ({push_i, pop_i})
        2'b10: begin
          if (!is_full) begin
            wr_en = 1'b1;
            top_d = ptr_inc(top_q);
            cnt_d = cnt_q + 1'b1;
          end else if (WrapOnFull) begin
            wr_en = 1'b1;
            top_d = ptr_inc(top_q);
          end else begin
            cause_d = CauseOverflow;
          end
        end
        2'b01: begin
          if (is_empty) begin
            cause_d = CauseUnderflow;
          end else begin
            if (!top_ok) cause_d = CauseMismatch;
            top_d = ptr_dec(top_q);
            cnt_d = cnt_q - 1'b1;
          end
        end
        2'b11: begin
          // Tail call: check the current top, then replace it in place.
          if (is_empty) begin
            cause_d = CauseUnderflow;
            wr_en   = 1'b1;
            top_d   = ptr_inc(top_q);
            cnt_d   = cnt_q + 1'b1;
          end else begin
            if (!top_ok) cause_d = CauseMismatch;
            wr_en  = 1'b1;
            wr_ptr = top_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= push_addr_i;
  end

  // Stage p1: registered stack state and error reporting
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      top_q     <= '0;
      cnt_q     <= '0;
      err_p1    <= 1'b0;
      cause_p1  <= CauseNone;
      sticky_p1 <= 1'b0;
    end else begin
      top_q    <= top_d;
      cnt_q    <= cnt_d;
      err_p1   <= (cause_d != CauseNone);
      cause_p1 <= cause_d;
      if (cause_d != CauseNone) sticky_p1 <= 1'b1;
      else if (err_clr_i)       sticky_p1 <= 1'b0;
    end
  end

  assign err_o        = err_p1;
  assign err_cause_o  = cause_p1;
  assign err_sticky_o = sticky_p1;
  assign depth_o      = cnt_q;
  assign full_o       = is_full;
  assign empty_o      = is_empty;

endmodule

// File: tb/tb_ibex_shadow_stack_ctrl.sv
// Bench for ibex_shadow_stack_ctrl: three parameter variants share one stimulus stream and are
// compared against queue-based reference models plus a directed table for the first variant.
module tb_ibex_shadow_stack_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, push, pop, flush, clr;
  logic [31:0] paddr, oaddr;
  logic [2:0]  err_w, sticky_w, full_w, empty_w;
  logic [1:0]  cause_w [3];
  logic [2:0]  depth_w [3];

  int checks = 0;
  int errors = 0;

  // Variant parameters: u0 D=4 drop/ignore-lsb, u1 D=4 wrap/full-compare, u2 D=5 wrap/ignore-lsb
  int md [3] = '{4, 4, 5};
  bit mw [3] = '{1'b0, 1'b1, 1'b1};
  bit mi [3] = '{1'b1, 1'b0, 1'b1};

  ibex_shadow_stack_ctrl #(.DataWidth(32), .Depth(4), .WrapOnFull(1'b0), .IgnoreLsb(1'b1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .push_i(push), .push_addr_i(paddr), .pop_i(pop),
    .pop_addr_i(oaddr), .flush_i(flush), .err_clr_i(clr), .err_o(err_w[0]),
    .err_cause_o(cause_w[0]), .err_sticky_o(sticky_w[0]), .depth_o(depth_w[0]),
    .full_o(full_w[0]), .empty_o(empty_w[0]));

  ibex_shadow_stack_ctrl #(.DataWidth(32), .Depth(4), .WrapOnFull(1'b1), .IgnoreLsb(1'b0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .push_i(push), .push_addr_i(paddr), .pop_i(pop),
    .pop_addr_i(oaddr), .flush_i(flush), .err_clr_i(clr), .err_o(err_w[1]),
    .err_cause_o(cause_w[1]), .err_sticky_o(sticky_w[1]), .depth_o(depth_w[1]),
    .full_o(full_w[1]), .empty_o(empty_w[1]));

  ibex_shadow_stack_ctrl #(.DataWidth(32), .Depth(5), .WrapOnFull(1'b1), .IgnoreLsb(1'b1)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .push_i(push), .push_addr_i(paddr), .pop_i(pop),
    .pop_addr_i(oaddr), .flush_i(flush), .err_clr_i(clr), .err_o(err_w[2]),
    .err_cause_o(cause_w[2]), .err_sticky_o(sticky_w[2]), .depth_o(depth_w[2]),
    .full_o(full_w[2]), .empty_o(empty_w[2]));

  // Reference model: back of the queue is the top of stack
  logic [31:0] mq [3][$];
  logic [1:0]  e_cause [3];
  bit   [2:0]  e_err, e_st;

  function automatic bit amatch(input bit ign, input logic [31:0] a, input logic [31:0] b);
    return ign ? (a[31:1] == b[31:1]) : (a == b);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      e_cause[k] = 2'd0;
      e_err[k]   = 1'b0;
      e_st[k]    = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [1:0]  c;
      logic [31:0] t;
      c = 2'd0;
      if (flush) begin
        mq[k].delete();
      end else if (en) begin
        if (push && pop) begin
          if (mq[k].size() == 0) begin
            c = 2'd3;
            mq[k].push_back(paddr);
          end else begin
            t = mq[k].pop_back();
            if (!amatch(mi[k], t, oaddr)) c = 2'd1;
            mq[k].push_back(paddr);
          end
        end else if (push) begin
          if (mq[k].size() < md[k]) begin
            mq[k].push_back(paddr);
          end else if (mw[k]) begin
            t = mq[k].pop_front();
            mq[k].push_back(paddr);
          end else begin
            c = 2'd2;
          end
        end else if (pop) begin
          if (mq[k].size() == 0) begin
            c = 2'd3;
          end else begin
            t = mq[k].pop_back();
            if (!amatch(mi[k], t, oaddr)) c = 2'd1;
          end
        end
      end
      e_cause[k] = c;
      e_err[k]   = (c != 2'd0);
      if (c != 2'd0) e_st[k] = 1'b1;
      else if (clr)  e_st[k] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      int sz;
      sz = mq[k].size();
      check($sformatf("%s u%0d err", tag, k),    32'(err_w[k]),    32'(e_err[k]));
      check($sformatf("%s u%0d cause", tag, k),  32'(cause_w[k]),  32'(e_cause[k]));
      check($sformatf("%s u%0d sticky", tag, k), 32'(sticky_w[k]), 32'(e_st[k]));
      check($sformatf("%s u%0d depth", tag, k),  32'(depth_w[k]),  32'(sz));
      check($sformatf("%s u%0d full", tag, k),   32'(full_w[k]),   32'(sz == md[k]));
      check($sformatf("%s u%0d empty", tag, k),  32'(empty_w[k]),  32'(sz == 0));
    end
  endtask

  task automatic drive(input bit f, input bit e, input bit pu, input logic [31:0] pa,
                       input bit po, input logic [31:0] oa, input bit c);
    flush = f; en = e; push = pu; paddr = pa; pop = po; oaddr = oa; clr = c;
  endtask

  task automatic cycle(input string tag, input bit f, input bit e, input bit pu,
                       input logic [31:0] pa, input bit po, input logic [31:0] oa, input bit c);
    drive(f, e, pu, pa, po, oa, c);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_consts(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s u%0d err", tag, k),    32'(err_w[k]),    32'd0);
      check($sformatf("%s u%0d cause", tag, k),  32'(cause_w[k]),  32'd0);
      check($sformatf("%s u%0d sticky", tag, k), 32'(sticky_w[k]), 32'd0);
      check($sformatf("%s u%0d depth", tag, k),  32'(depth_w[k]),  32'd0);
      check($sformatf("%s u%0d full", tag, k),   32'(full_w[k]),   32'd0);
      check($sformatf("%s u%0d empty", tag, k),  32'(empty_w[k]),  32'd1);
    end
  endtask

  // Directed vectors with hand-derived expectations for u0 (Depth 4, drop on full, lsb ignored)
  typedef struct {
    bit f, e, pu; logic [31:0] pa; bit po; logic [31:0] oa; bit c;
    bit x_err; logic [1:0] x_cause; bit x_st; int x_depth;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input bit f, input bit e, input bit pu, input logic [31:0] pa,
                     input bit po, input logic [31:0] oa, input bit c,
                     input bit xe, input logic [1:0] xc, input bit xs, input int xd);
    vec_t v;
    v.f = f; v.e = e; v.pu = pu; v.pa = pa; v.po = po; v.oa = oa; v.c = c;
    v.x_err = xe; v.x_cause = xc; v.x_st = xs; v.x_depth = xd;
    tbl.push_back(v);
  endtask

  initial begin
    add(0,1,1,32'h100,0,32'h0,0, 0,2'd0,0,1);
    add(0,1,1,32'h200,0,32'h0,0, 0,2'd0,0,2);
    add(0,1,1,32'h300,0,32'h0,0, 0,2'd0,0,3);
    add(0,1,0,32'h0,1,32'h300,0, 0,2'd0,0,2);
    add(0,1,0,32'h0,1,32'h200,0, 0,2'd0,0,1);
    add(0,1,0,32'h0,1,32'h100,0, 0,2'd0,0,0);
    add(0,1,1,32'h100,0,32'h0,0, 0,2'd0,0,1);
    add(0,1,0,32'h0,1,32'h104,0, 1,2'd1,1,0);
    add(0,1,0,32'h0,0,32'h0,0,   0,2'd0,1,0);
    add(0,1,0,32'h0,0,32'h0,1,   0,2'd0,0,0);
    add(0,1,1,32'h100,0,32'h0,0, 0,2'd0,0,1);
    add(0,1,0,32'h0,1,32'h101,0, 0,2'd0,0,0);
    add(0,1,1,32'h10,0,32'h0,0,  0,2'd0,0,1);
    add(0,1,1,32'h20,0,32'h0,0,  0,2'd0,0,2);
    add(0,1,1,32'h30,0,32'h0,0,  0,2'd0,0,3);
    add(0,1,1,32'h40,0,32'h0,0,  0,2'd0,0,4);
    add(0,1,1,32'h50,0,32'h0,0,  1,2'd2,1,4);
    add(0,1,1,32'hA0,1,32'h40,0, 0,2'd0,1,4);
    add(0,1,0,32'h0,1,32'hA0,0,  0,2'd0,1,3);
    add(0,1,0,32'h0,1,32'h30,0,  0,2'd0,1,2);
    add(0,1,0,32'h0,1,32'h20,0,  0,2'd0,1,1);
    add(0,1,0,32'h0,1,32'h10,0,  0,2'd0,1,0);
    add(0,1,0,32'h0,1,32'h0,0,   1,2'd3,1,0);
    add(0,1,1,32'h77,1,32'h0,0,  1,2'd3,1,1);
    add(1,1,1,32'h88,0,32'h0,0,  0,2'd0,1,0);
    add(0,1,0,32'h0,1,32'h0,1,   1,2'd3,1,0);
    add(0,0,1,32'h5,0,32'h0,0,   0,2'd0,1,0);
    add(0,1,0,32'h0,0,32'h0,1,   0,2'd0,0,0);

    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_consts("reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post-reset idle");

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("tbl%0d", i);
      cycle(tag, tbl[i].f, tbl[i].e, tbl[i].pu, tbl[i].pa, tbl[i].po, tbl[i].oa, tbl[i].c);
      check({tag, " vec err"},    32'(err_w[0]),    32'(tbl[i].x_err));
      check({tag, " vec cause"},  32'(cause_w[0]),  32'(tbl[i].x_cause));
      check({tag, " vec sticky"}, 32'(sticky_w[0]), 32'(tbl[i].x_st));
      check({tag, " vec depth"},  32'(depth_w[0]),  32'(tbl[i].x_depth));
      check({tag, " vec full"},   32'(full_w[0]),   32'(tbl[i].x_depth == 4));
      check({tag, " vec empty"},  32'(empty_w[0]),  32'(tbl[i].x_depth == 0));
    end

    // Overwrite-on-full: five pushes keep the newest four, fifth pop underflows
    cycle("wrap flush", 1, 1, 0, 32'h0, 0, 32'h0, 1);
    for (int i = 1; i <= 5; i++) cycle("wrap push", 0, 1, 1, 32'(i * 16), 0, 32'h0, 0);
    for (int i = 5; i >= 2; i--) begin
      cycle("wrap pop", 0, 1, 0, 32'h0, 1, 32'(i * 16), 0);
      check("wrap pop clean u1", 32'(err_w[1]), 32'd0);
    end
    cycle("wrap pop5", 0, 1, 0, 32'h0, 1, 32'h10, 0);
    check("wrap pop5 u1 cause", 32'(cause_w[1]), 32'd3);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      bit f, e, pu, po, c;
      logic [31:0] pa, oa;
      int k;
      f  = ($urandom % 40) == 0;
      e  = ($urandom % 12) != 0;
      pu = ($urandom % 100) < ((i / 150) % 2 == 0 ? 65 : 40);
      po = ($urandom % 100) < 50;
      c  = ($urandom % 15) == 0;
      pa = $urandom & 32'h0000_0FFF;
      k  = $urandom % 3;
      if (mq[k].size() > 0 && ($urandom % 4) != 0)
        oa = mq[k][mq[k].size()-1] ^ 32'(($urandom % 4) == 0);
      else
        oa = $urandom & 32'h0000_0FFF;
      cycle("rand", f, e, pu, pa, po, oa, c);
    end

    // Asynchronous reset in the middle of an offending cycle drops the pending error
    cycle("ar push", 0, 1, 1, 32'h1234, 0, 32'h0, 0);
    cycle("ar bad pop", 0, 1, 0, 32'h0, 1, 32'h9998, 0);
    drive(0, 1, 0, 32'h0, 1, 32'h5554, 0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_consts("async reset");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_consts("during reset");
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("after async reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
